fetch: RTL and testbench
========================

FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter ADDRESS_SIZE, default 32, instruction and address width in bits.
REQ-002 Parameter RESET_PC, default 32'h0, first fetch address after reset.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 stall  input  1  decode backpressure; 1 = decode does not consume the current output this cycle.
REQ-006 branch_taken  input  1  one-cycle redirect request from execute.
REQ-007 branch_target  input  ADDRESS_SIZE  redirect address, sampled when branch_taken=1.
REQ-008 mem_req  output  1  instruction memory request valid.
REQ-009 mem_addr  output  ADDRESS_SIZE  word-aligned request address.
REQ-010 mem_ready  input  1  memory accepts the request and returns mem_data in the same cycle.
REQ-011 mem_data  input  ADDRESS_SIZE  returned instruction word.
REQ-012 instruction  output  ADDRESS_SIZE  instruction to decoder, registered.
REQ-013 pc_out  output  ADDRESS_SIZE  address of the current instruction.
REQ-014 valid  output  1  instruction/pc_out hold a live instruction.

Function
REQ-015 Storage: internal pc, output register (instruction/pc_out/valid) and one-entry skid buffer; occupancy 0..2.
REQ-016 Consumption: output is consumed on any edge with valid=1 and stall=0.
REQ-017 Output register load priority when empty or consumed: skid entry, else memory return (mem_req & mem_ready), else valid=0.
REQ-018 Memory return while output is held (valid=1, stall=1) SHALL go to the skid buffer.
REQ-019 When valid=0, instruction SHALL read 32'b0 (NOP) and pc_out SHALL hold its last value.
REQ-020 FSM states: IDLE, FETCH, HOLD, DRAIN.
REQ-021 IDLE: mem_req=0; next edge after reset release -> FETCH.
REQ-022 FETCH: mem_req=1, mem_addr=pc; mem_addr SHALL stay stable until mem_ready=1.
REQ-023 FETCH on mem_ready: pc <= pc+4; -> HOLD if occupancy becomes 2, else stay FETCH.
REQ-024 HOLD: mem_req=0; -> FETCH on the edge where the output is consumed.
REQ-025 Fetch throughput: one instruction per cycle when mem_ready=1 continuously and stall=0.
REQ-026 pc arithmetic is modulo 2^ADDRESS_SIZE; 32'hFFFFFFFC+4 wraps to 32'h0.
REQ-027 branch_taken SHALL have priority over stall and over any memory return.
REQ-028 On branch_taken: valid and skid cleared at the edge; pc <= {branch_target[ADDRESS_SIZE-1:2],2'b00}.
REQ-029 branch_taken in FETCH with mem_ready=0 -> DRAIN; the outstanding address is held on mem_addr.
REQ-030 branch_taken in FETCH with mem_ready=1 -> FETCH at the target; returned data discarded.
REQ-031 branch_taken in IDLE or HOLD -> FETCH at the target.
REQ-032 DRAIN: mem_req=1 at the old address; on mem_ready the data is discarded and the state -> FETCH at the saved target.
REQ-033 A second branch_taken during DRAIN SHALL overwrite the saved target and keep the FSM in DRAIN unless mem_ready=1 in the same cycle.
REQ-034 No instruction from a pre-branch address SHALL ever appear with valid=1 after branch_taken.

Reset
REQ-035 reset=1 SHALL immediately and asynchronously force: state IDLE, pc=RESET_PC, mem_req=0, mem_addr=RESET_PC, instruction=0, pc_out=0, valid=0, skid empty.
REQ-036 Reset asserted mid-request SHALL abandon the request; a mem_ready arriving during reset SHALL be ignored.
REQ-037 First request after reset SHALL appear one cycle after reset deassertion, at RESET_PC.

Verification
REQ-038 Reset release, mem_ready=1 constant, stall=0 -> mem_addr 0,4,8,... one per cycle; valid rises one cycle after the first accept; pc_out 0,4,8.
REQ-039 stall=1 held for 4 cycles while streaming -> output frozen, one more word enters skid, mem_req=0 (HOLD); on stall=0 the words follow in order with no loss or duplication.
REQ-040 branch_taken with branch_target=32'h103 while mem_ready=0 -> DRAIN; old address held; late data dropped; next mem_addr=32'h100; next valid pc_out=32'h100.
REQ-041 branch_taken and stall=1 in the same cycle with a full skid -> valid=0 next cycle; fetch resumes at the target.
REQ-042 pc=32'hFFFFFFFC fetched -> next mem_addr=32'h0.
REQ-043 reset pulsed while mem_req=1 and valid=1 -> all outputs at reset values within the same cycle; restart at RESET_PC.

Source files
------------

// File: rtl/fetch.sv
// Instruction fetch stage: drives a single-cycle-response instruction memory and feeds decode
// through a registered output stage backed by a one-entry skid buffer, with branch redirect.
module fetch #(
    parameter int                      ADDRESS_SIZE = 32,
    parameter logic [ADDRESS_SIZE-1:0] RESET_PC     = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    branch_taken,
    input  logic [ADDRESS_SIZE-1:0] branch_target,
    output logic                    mem_req,
    output logic [ADDRESS_SIZE-1:0] mem_addr,
    input  logic                    mem_ready,
    input  logic [ADDRESS_SIZE-1:0] mem_data,
    output logic [ADDRESS_SIZE-1:0] instruction,
    output logic [ADDRESS_SIZE-1:0] pc_out,
    output logic                    valid,
    output logic [1:0]              fsm_state
);

    // Handshake: a memory transfer happens on an edge where mem_req=1 and mem_ready=1;
    // the output is consumed on an edge where valid=1 and stall=0.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                  state, state_n;
    logic [ADDRESS_SIZE-1:0] pc, pc_n;
    logic [ADDRESS_SIZE-1:0] target, target_n;
    logic [ADDRESS_SIZE-1:0] instr_n, pc_out_n;
    logic                    valid_n;
    logic [ADDRESS_SIZE-1:0] skid_data, skid_data_n;
    logic [ADDRESS_SIZE-1:0] skid_pc, skid_pc_n;
    logic                    skid_valid, skid_valid_n;

    logic                    fetch_ret;
    logic                    consumed;
    logic                    out_free;
    logic [ADDRESS_SIZE-1:0] br_aligned;
    logic [ADDRESS_SIZE-1:0] pc_inc;

    assign fsm_state  = state;
    assign br_aligned = branch_target & ~ADDRESS_SIZE'(3);
    assign pc_inc     = pc + ADDRESS_SIZE'(4);
    assign fetch_ret  = (state == FETCH) && mem_ready;
    assign consumed   = valid && !stall;
    assign out_free   = !valid || consumed;

    // pc is left untouched while draining so mem_addr keeps presenting the outstanding address.
    assign mem_req  = (state == FETCH) || (state == DRAIN);
    assign mem_addr = pc;

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        target_n     = target;
        instr_n      = instruction;
        pc_out_n     = pc_out;
        valid_n      = valid;
        skid_data_n  = skid_data;
        skid_pc_n    = skid_pc;
        skid_valid_n = skid_valid;

        if (branch_taken) begin
            valid_n      = 1'b0;
            instr_n      = '0;
            skid_valid_n = 1'b0;
            case (state)
                FETCH: begin
                    if (mem_ready) begin
                        pc_n = br_aligned;
                    end else begin
                        target_n = br_aligned;
                        state_n  = DRAIN;
                    end
                end
                DRAIN: begin
                    if (mem_ready) begin
                        pc_n    = br_aligned;
                        state_n = FETCH;
                    end else begin
                        target_n = br_aligned;
                    end
                end
                default: begin
                    pc_n    = br_aligned;
                    state_n = FETCH;
                end
            endcase
        end else begin
            if (out_free) begin
                if (skid_valid) begin
                    instr_n      = skid_data;
                    pc_out_n     = skid_pc;
                    valid_n      = 1'b1;
                    skid_valid_n = fetch_ret;
                    if (fetch_ret) begin
                        skid_data_n = mem_data;
                        skid_pc_n   = pc;
                    end
                end else if (fetch_ret) begin
                    instr_n  = mem_data;
                    pc_out_n = pc;
                    valid_n  = 1'b1;
                end else begin
                    instr_n = '0;
                    valid_n = 1'b0;
                end
            end else if (fetch_ret) begin
                skid_data_n  = mem_data;
                skid_pc_n    = pc;
                skid_valid_n = 1'b1;
            end

            case (state)
                IDLE: state_n = FETCH;
                FETCH: begin
                    if (mem_ready) begin
                        pc_n = pc_inc;
                        if (valid_n && skid_valid_n) state_n = HOLD;
                    end
                end
                HOLD: begin
                    if (consumed) state_n = FETCH;
                end
                DRAIN: begin
                    if (mem_ready) begin
                        pc_n    = target;
                        state_n = FETCH;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            target      <= RESET_PC;
            instruction <= '0;
            pc_out      <= '0;
            valid       <= 1'b0;
            skid_data   <= '0;
            skid_pc     <= '0;
            skid_valid  <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            target      <= target_n;
            instruction <= instr_n;
            pc_out      <= pc_out_n;
            valid       <= valid_n;
            skid_data   <= skid_data_n;
            skid_pc     <= skid_pc_n;
            skid_valid  <= skid_valid_n;
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for the fetch stage; memory returns address XOR a fixed tag so each word is traceable.
module tb_fetch;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_data;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        valid;
    logic [1:0]  fsm_state;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] TAG = 32'hC0DE_0000;
    localparam logic [1:0] S_IDLE = 2'd0, S_FETCH = 2'd1, S_HOLD = 2'd2, S_DRAIN = 2'd3;

    fetch dut (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data),
        .instruction(instruction), .pc_out(pc_out), .valid(valid), .fsm_state(fsm_state)
    );

    assign mem_data = mem_addr ^ TAG;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ TAG;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0; mem_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0; mem_ready = 1'b0;
        #2;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b exp 0", mem_req); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr: got %h exp 0", mem_addr); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b exp 0", valid); end
        total++; if (instruction !== 32'h0) begin bad++; $display("FAIL rst_instr: got %h exp 0", instruction); end
        total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL rst_pc_out: got %h exp 0", pc_out); end
        total++; if (fsm_state !== S_IDLE) begin bad++; $display("FAIL rst_state: got %0d exp %0d", fsm_state, S_IDLE); end
        tick();
        mem_ready = 1'b1;
        reset = 1'b0;
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_rel_req: got %b exp 0", mem_req); end
        tick();
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin bad++; $display("FAIL first_req: got req=%b addr=%h exp req=1 addr=0", mem_req, mem_addr); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL first_valid: got %b exp 0", valid); end
    endtask

    task automatic test_stream();
        do_reset();
        mem_ready = 1'b1;
        tick();
        total++; if (mem_addr !== 32'h0 || valid !== 1'b0) begin bad++; $display("FAIL stream_start: got addr=%h valid=%b exp 0/0", mem_addr, valid); end
        for (int k = 0; k < 6; k++) begin
            tick();
            total++;
            if (valid !== 1'b1 || pc_out !== 32'(4*k) || instruction !== dat(32'(4*k)) || mem_addr !== 32'(4*k+4)) begin
                bad++;
                $display("FAIL stream_%0d: got v=%b pc=%h ins=%h addr=%h exp v=1 pc=%h ins=%h addr=%h",
                         k, valid, pc_out, instruction, mem_addr, 32'(4*k), dat(32'(4*k)), 32'(4*k+4));
            end
        end
    endtask

    // Leaves the DUT in HOLD with pc_out=4 on the output and word 8 in the skid, pc=12.
    task automatic fill_to_hold();
        do_reset();
        mem_ready = 1'b1;
        tick(); tick(); tick();
        stall = 1'b1;
        tick();
    endtask

    task automatic test_stall();
        fill_to_hold();
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            total++;
            if (valid !== 1'b1 || pc_out !== 32'h4 || instruction !== dat(32'h4) || mem_req !== 1'b0 || fsm_state !== S_HOLD) begin
                bad++;
                $display("FAIL stall_hold_%0d: got v=%b pc=%h ins=%h req=%b st=%0d exp v=1 pc=4 ins=%h req=0 st=2",
                         k, valid, pc_out, instruction, mem_req, fsm_state, dat(32'h4));
            end
        end
        stall = 1'b0;
        tick();
        total++; if (pc_out !== 32'h8 || instruction !== dat(32'h8) || mem_req !== 1'b1 || mem_addr !== 32'hC) begin
            bad++; $display("FAIL stall_rel0: got pc=%h ins=%h req=%b addr=%h exp pc=8 req=1 addr=c", pc_out, instruction, mem_req, mem_addr); end
        tick();
        total++; if (pc_out !== 32'hC || instruction !== dat(32'hC) || valid !== 1'b1) begin
            bad++; $display("FAIL stall_rel1: got pc=%h ins=%h v=%b exp pc=c", pc_out, instruction, valid); end
        tick();
        total++; if (pc_out !== 32'h10 || instruction !== dat(32'h10)) begin
            bad++; $display("FAIL stall_rel2: got pc=%h ins=%h exp pc=10", pc_out, instruction); end
    endtask

    task automatic test_branch_drain();
        do_reset();
        mem_ready = 1'b1;
        tick(); tick(); tick();
        mem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h103;
        tick();
        branch_taken = 1'b0;
        total++; if (fsm_state !== S_DRAIN || mem_req !== 1'b1 || mem_addr !== 32'h8) begin
            bad++; $display("FAIL drain_enter: got st=%0d req=%b addr=%h exp st=3 req=1 addr=8", fsm_state, mem_req, mem_addr); end
        total++; if (valid !== 1'b0 || instruction !== 32'h0 || pc_out !== 32'h4) begin
            bad++; $display("FAIL drain_out: got v=%b ins=%h pc=%h exp v=0 ins=0 pc=4", valid, instruction, pc_out); end
        tick();
        total++; if (fsm_state !== S_DRAIN || mem_addr !== 32'h8) begin
            bad++; $display("FAIL drain_wait: got st=%0d addr=%h exp st=3 addr=8", fsm_state, mem_addr); end
        mem_ready = 1'b1;
        tick();
        total++; if (fsm_state !== S_FETCH || valid !== 1'b0 || mem_addr !== 32'h100) begin
            bad++; $display("FAIL drain_done: got st=%0d v=%b addr=%h exp st=1 v=0 addr=100", fsm_state, valid, mem_addr); end
        tick();
        total++; if (valid !== 1'b1 || pc_out !== 32'h100 || instruction !== dat(32'h100) || mem_addr !== 32'h104) begin
            bad++; $display("FAIL drain_target: got v=%b pc=%h ins=%h addr=%h exp v=1 pc=100 addr=104", valid, pc_out, instruction, mem_addr); end
    endtask

    task automatic test_double_branch();
        do_reset();
        tick();
        tick();
        total++; if (fsm_state !== S_FETCH || mem_addr !== 32'h0 || mem_req !== 1'b1) begin
            bad++; $display("FAIL wait_stable: got st=%0d addr=%h req=%b exp st=1 addr=0 req=1", fsm_state, mem_addr, mem_req); end
        branch_taken = 1'b1; branch_target = 32'h100;
        tick();
        branch_target = 32'h200;
        tick();
        branch_taken = 1'b0;
        total++; if (fsm_state !== S_DRAIN || mem_addr !== 32'h0) begin
            bad++; $display("FAIL dbl_drain: got st=%0d addr=%h exp st=3 addr=0", fsm_state, mem_addr); end
        mem_ready = 1'b1;
        tick();
        total++; if (mem_addr !== 32'h200 || valid !== 1'b0) begin
            bad++; $display("FAIL dbl_target: got addr=%h v=%b exp addr=200 v=0", mem_addr, valid); end
        tick();
        total++; if (valid !== 1'b1 || pc_out !== 32'h200 || instruction !== dat(32'h200)) begin
            bad++; $display("FAIL dbl_out: got v=%b pc=%h ins=%h exp v=1 pc=200", valid, pc_out, instruction); end
    endtask

    task automatic test_branch_stall();
        fill_to_hold();
        branch_taken = 1'b1; branch_target = 32'h40;
        tick();
        branch_taken = 1'b0; stall = 1'b0;
        total++; if (valid !== 1'b0 || instruction !== 32'h0 || mem_req !== 1'b1 || mem_addr !== 32'h40) begin
            bad++; $display("FAIL brstall_clear: got v=%b ins=%h req=%b addr=%h exp v=0 ins=0 req=1 addr=40", valid, instruction, mem_req, mem_addr); end
        tick();
        total++; if (valid !== 1'b1 || pc_out !== 32'h40 || instruction !== dat(32'h40)) begin
            bad++; $display("FAIL brstall_resume: got v=%b pc=%h ins=%h exp v=1 pc=40", valid, pc_out, instruction); end
        tick();
        total++; if (pc_out !== 32'h44) begin bad++; $display("FAIL brstall_next: got pc=%h exp 44", pc_out); end
    endtask

    task automatic test_wrap();
        do_reset();
        mem_ready = 1'b1;
        tick();
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE;
        tick();
        branch_taken = 1'b0;
        total++; if (mem_addr !== 32'hFFFF_FFFC || valid !== 1'b0) begin
            bad++; $display("FAIL wrap_target: got addr=%h v=%b exp addr=fffffffc v=0", mem_addr, valid); end
        tick();
        total++; if (pc_out !== 32'hFFFF_FFFC || mem_addr !== 32'h0 || valid !== 1'b1) begin
            bad++; $display("FAIL wrap_addr: got pc=%h addr=%h v=%b exp pc=fffffffc addr=0 v=1", pc_out, mem_addr, valid); end
        tick();
        total++; if (pc_out !== 32'h0 || instruction !== dat(32'h0) || mem_addr !== 32'h4) begin
            bad++; $display("FAIL wrap_next: got pc=%h ins=%h addr=%h exp pc=0 addr=4", pc_out, instruction, mem_addr); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_ready = 1'b1;
        tick(); tick(); tick(); tick();
        reset = 1'b1;
        #1;
        total++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || valid !== 1'b0 || instruction !== 32'h0 || pc_out !== 32'h0) begin
            bad++; $display("FAIL async_rst: got req=%b addr=%h v=%b ins=%h pc=%h exp all 0", mem_req, mem_addr, valid, instruction, pc_out); end
        tick();
        total++; if (mem_req !== 1'b0 || valid !== 1'b0 || fsm_state !== S_IDLE) begin
            bad++; $display("FAIL rst_hold: got req=%b v=%b st=%0d exp 0/0/0", mem_req, valid, fsm_state); end
        reset = 1'b0;
        tick();
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            bad++; $display("FAIL restart_req: got req=%b addr=%h exp req=1 addr=0", mem_req, mem_addr); end
        tick();
        total++; if (valid !== 1'b1 || pc_out !== 32'h0 || instruction !== dat(32'h0)) begin
            bad++; $display("FAIL restart_out: got v=%b pc=%h ins=%h exp v=1 pc=0", valid, pc_out, instruction); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_branch_drain();
        test_double_branch();
        test_branch_stall();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
